// File: rtl/timer.sv
// CHIP-8 countdown timer (delay/sound): loads an 8-bit value and decrements it at TICK_HZ until zero.
// Optional `active` output is built when TIMER_ACTIVE_EN is defined.
module timer #(
  parameter int fps     = 27000000,
  parameter int TICK_HZ = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       set,
  input  logic [7:0] time_in,
  output logic [7:0] time_out
`ifdef TIMER_ACTIVE_EN
  ,
  output logic       active
`endif
);

  localparam int DIV_RAW = fps / TICK_HZ;
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int PRE_W   = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);

  logic [PRE_W-1:0] r_pre;
  logic [7:0]       r_time;
  logic             w_tick;
  logic [PRE_W-1:0] w_pre_next;
  logic [7:0]       w_time_next;

  // With DIV == 1 the prescaler sits at 0 and ticks every cycle.
  always_comb begin
    w_tick      = (r_pre == PRE_LAST);
    w_pre_next  = w_tick ? '0 : r_pre + 1'b1;
    w_time_next = r_time;
    if (set) begin
      w_time_next = time_in;
    end else if (w_tick && (r_time != 8'd0)) begin
      w_time_next = r_time - 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pre  <= '0;
      r_time <= 8'd0;
    end else begin
      r_pre  <= set ? '0 : w_pre_next;
      r_time <= w_time_next;
    end
  end

  assign time_out = r_time;

`ifdef TIMER_ACTIVE_EN
  logic r_active;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_active <= 1'b0;
    end else begin
      r_active <= (w_time_next != 8'd0);
    end
  end

  assign active = r_active;
`endif

endmodule

// File: tb/tb_timer.sv
// Bench for timer: three instances (default rate, DIV=10, DIV=1) share one stimulus stream
// and are checked every cycle against an arithmetic countdown model.
module tb_timer;

  localparam int DIV_DEF = 27000000 / 60;
  localparam int DIV_TEN = 10;
  localparam int DIV_ONE = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       set = 1'b0;
  logic [7:0] time_in = 8'd0;
  logic [7:0] out_def, out_ten, out_one;
`ifdef TIMER_ACTIVE_EN
  logic act_def, act_ten, act_one;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: value loaded and the edge index it was loaded (or reset) on.
  int edge_cnt  = 0;
  int load_edge = 0;
  int load_val  = 0;

  always #5 clk = ~clk;

  timer dut_def (
    .clk(clk), .rst(rst), .set(set), .time_in(time_in), .time_out(out_def)
`ifdef TIMER_ACTIVE_EN
    , .active(act_def)
`endif
  );

  timer #(.fps(600), .TICK_HZ(60)) dut_ten (
    .clk(clk), .rst(rst), .set(set), .time_in(time_in), .time_out(out_ten)
`ifdef TIMER_ACTIVE_EN
    , .active(act_ten)
`endif
  );

  timer #(.fps(60), .TICK_HZ(60)) dut_one (
    .clk(clk), .rst(rst), .set(set), .time_in(time_in), .time_out(out_one)
`ifdef TIMER_ACTIVE_EN
    , .active(act_one)
`endif
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s edge=%0d got=%0d expected=%0d", tag, edge_cnt, got, exp);
    end
  endtask

  function automatic int expected(input int div);
    int v;
    v = load_val - (edge_cnt - load_edge) / div;
    return (v < 0) ? 0 : v;
  endfunction

  // Drive one cycle, advance the model on the edge, then compare all instances.
  task automatic step(input bit r, input bit s, input logic [7:0] v);
    rst     = r;
    set     = s;
    time_in = v;
    @(posedge clk);
    edge_cnt++;
    if (r) begin
      load_val  = 0;
      load_edge = edge_cnt;
    end else if (s) begin
      load_val  = int'(v);
      load_edge = edge_cnt;
    end
    #1;
    check("def_time", int'(out_def), expected(DIV_DEF));
    check("ten_time", int'(out_ten), expected(DIV_TEN));
    check("one_time", int'(out_one), expected(DIV_ONE));
`ifdef TIMER_ACTIVE_EN
    check("def_active", int'(act_def), int'(expected(DIV_DEF) != 0));
    check("ten_active", int'(act_ten), int'(expected(DIV_TEN) != 0));
    check("one_active", int'(act_one), int'(expected(DIV_ONE) != 0));
`endif
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'($urandom));
  endtask

  initial begin
    step(1'b1, 1'b0, 8'd0);
    step(1'b1, 1'b0, 8'd0);
    $display("reset done, checks=%0d", n_checks);

    step(1'b0, 1'b1, 8'd8);
    idle(50);
    $display("load 8, held 50 cycles: def=%0d", out_def);

    step(1'b0, 1'b1, 8'd3);
    idle(130);
    $display("load 3, countdown to zero: ten=%0d", out_ten);

    step(1'b0, 1'b1, 8'd5);
    idle(6);
    step(1'b1, 1'b0, 8'd0);
    idle(20);
    $display("load 5, reset mid-countdown: ten=%0d", out_ten);

    step(1'b0, 1'b1, 8'd4);
    idle(9);
    step(1'b0, 1'b1, 8'd9);
    idle(25);
    $display("load 4, reload 9 on tick edge: ten=%0d", out_ten);

    step(1'b0, 1'b1, 8'd255);
    idle(260);
    step(1'b0, 1'b1, 8'd0);
    idle(20);
    $display("load 255 then 0: one=%0d", out_one);

    step(1'b1, 1'b1, 8'h42);
    idle(5);
    $display("rst and set together: def=%0d", out_def);

    for (int i = 0; i < 15; i++) step(1'b0, 1'b1, 8'($urandom));
    idle(12);
    $display("set held high 15 cycles: ten=%0d", out_ten);

    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(63) == 0), ($urandom_range(11) == 0), 8'($urandom));
    end
    $display("random phase done, checks=%0d", n_checks);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
